// File: rtl/tetris_pkg.sv
// Shared types and constants for the playfield line-clear engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package tetris_pkg;

    // Default playfield geometry
    localparam int DEF_ROWS = 22;
    localparam int DEF_COLS = 10;
    localparam int DEF_CW   = 3;

    // Points awarded per clear size; anything above four lines pays the maximum
    localparam logic [15:0] SCORE_1 = 16'd40;
    localparam logic [15:0] SCORE_2 = 16'd100;
    localparam logic [15:0] SCORE_3 = 16'd300;
    localparam logic [15:0] SCORE_4 = 16'd1200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_FILL,
        S_DONE
    } state_t;

    // Map a line count onto its score, saturating at the four-line value
    function automatic logic [15:0] score_for(input int unsigned n);
        if (n == 0)      return 16'd0;
        else if (n == 1) return SCORE_1;
        else if (n == 2) return SCORE_2;
        else if (n == 3) return SCORE_3;
        else             return SCORE_4;
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Flags a row whose every cell holds a nonzero colour.
// Latency: combinational.
// Backpressure: none.
module row_full_detect #(
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic [COLS-1:0][CW-1:0] row,
    output logic                    full
);

    // Any empty cell disqualifies the row
    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c] == '0) full = 1'b0;
        end
    end

endmodule

// File: rtl/grid_clear_engine.sv
// Removes full rows from a playfield and compacts the survivors downward in place.
// Latency: 2 + ROWS + lines_cleared cycles from accepted start to the done pulse.
// Backpressure: none; start is only sampled while idle. GRID_CLEAR_SCORE_EN enables the score table.
module grid_clear_engine
    import tetris_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int CW   = DEF_CW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_in,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_out,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(ROWS+1)-1:0]        lines_cleared,
    output logic [15:0]                      score_delta
);

    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LW = $clog2(ROWS+1);
    localparam logic [PW-1:0] RMAX = PW'(ROWS-1);

    state_t state, next_state;

    logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_q;
    logic [PW-1:0] rd, wr, rd_idx;
    logic [LW-1:0] cnt, cnt_d, lines_q;
    logic          row_full;

    // rd wraps below zero on the final scan step; clamp so the detector never indexes off the array
    assign rd_idx = (rd <= RMAX) ? rd : '0;

    row_full_detect #(
        .COLS (COLS),
        .CW   (CW)
    ) u_row_full (
        .row  (grid_q[rd_idx]),
        .full (row_full)
    );

    // Line count including the row being examined this cycle
    always_comb begin
        cnt_d = cnt;
        if (state == S_SCAN && row_full) cnt_d = cnt + LW'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state: scan ends on row 0; fill ends once row 0 has been blanked
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = S_SCAN;
            S_SCAN:  if (rd == '0) next_state = (cnt_d != '0) ? S_FILL : S_DONE;
            S_FILL:  if (wr == '0) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_LOAD) || (state == S_SCAN) || (state == S_FILL);
        done = (state == S_DONE);
    end

    // Working array, pointers and line counter; results latch on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q  <= '0;
            rd      <= RMAX;
            wr      <= RMAX;
            cnt     <= '0;
            lines_q <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    grid_q <= grid_in;
                    rd     <= RMAX;
                    wr     <= RMAX;
                    cnt    <= '0;
                end
                S_SCAN: begin
                    if (row_full) begin
                        cnt <= cnt_d;
                    end else begin
                        grid_q[wr] <= grid_q[rd_idx];
                        wr         <= wr - PW'(1);
                    end
                    rd <= rd - PW'(1);
                end
                S_FILL: begin
                    grid_q[wr] <= '0;
                    wr         <= wr - PW'(1);
                end
                default: ;
            endcase
            if (state != S_DONE && next_state == S_DONE) lines_q <= cnt_d;
        end
    end

    assign grid_out      = grid_q;
    assign lines_cleared = lines_q;

`ifdef GRID_CLEAR_SCORE_EN
    logic [15:0] score_q;

    // Score tracks the line count, latched alongside it on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) score_q <= '0;
        else if (state != S_DONE && next_state == S_DONE) score_q <= score_for(32'(cnt_d));
    end

    assign score_delta = score_q;
`else
    assign score_delta = 16'd0;
`endif

endmodule

// File: tb/tb_grid_clear_engine.sv
// Directed bench for grid_clear_engine at the default 22x10x3 geometry.
// Latency: n/a.
// Backpressure: n/a.
module tb_grid_clear_engine;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int CW   = 3;
    localparam int GW   = ROWS*COLS*CW;

    typedef logic [COLS-1:0][CW-1:0]           row_t;
    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    grid_t       grid_in;
    grid_t       grid_out;
    logic        busy;
    logic        done;
    logic [4:0]  lines_cleared;
    logic [15:0] score_delta;

    int checks   = 0;
    int failures = 0;

    grid_clear_engine #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CW   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .grid_in       (grid_in),
        .grid_out      (grid_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score_delta   (score_delta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_score(input int n);
`ifdef GRID_CLEAR_SCORE_EN
        case (n)
            0:       return 16'd0;
            1:       return 16'd40;
            2:       return 16'd100;
            3:       return 16'd300;
            default: return 16'd1200;
        endcase
`else
        return 16'd0 + 16'(n & 0);
`endif
    endfunction

    function automatic row_t full_row(input int c);
        row_t r;
        for (int i = 0; i < COLS; i++) r[i] = 3'((c % 7) + 1);
        return r;
    endfunction

    // Non-full row with a row-specific signature so ordering can be checked
    function automatic row_t partial_row(input int n);
        row_t r;
        r    = '0;
        r[1] = 3'((n % 7) + 1);
        r[2] = 3'(((n / 7) % 7) + 1);
        return r;
    endfunction

    // Launch one operation, measure latency, then check results and post-done idle
    task automatic run_op(input string name, input grid_t g, input grid_t exp_g,
                          input int exp_l, input bit hold_start);
        int cyc;
        bit seen;
        grid_in = g;
        start   = 1'b1;
        cyc     = 0;
        seen    = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            if (cyc == 2) grid_in = ~g;
            if (done) seen = 1'b1;
        end
        chk({name, "_latency"}, GW'(cyc), GW'(2 + ROWS + exp_l));
        chk({name, "_busy_in_done"}, GW'(busy), GW'(0));
        chk({name, "_lines"}, GW'(lines_cleared), GW'(exp_l));
        chk({name, "_score"}, GW'(score_delta), GW'(exp_score(exp_l)));
        chk({name, "_grid"}, GW'(grid_out), GW'(exp_g));
        // start may still be high here; DONE must not honour it
        @(negedge clk);
        start = 1'b0;
        chk({name, "_idle_busy"}, GW'(busy), GW'(0));
        chk({name, "_idle_done"}, GW'(done), GW'(0));
        chk({name, "_hold_lines"}, GW'(lines_cleared), GW'(exp_l));
        @(negedge clk);
        chk({name, "_stay_idle"}, GW'(busy), GW'(0));
    endtask

    initial begin
        grid_t g, e, g2, e2;
        int done_cnt;

        rst_n   = 1'b0;
        start   = 1'b0;
        grid_in = '0;
        #1;
        chk("rst_busy", GW'(busy), GW'(0));
        chk("rst_done", GW'(done), GW'(0));
        chk("rst_lines", GW'(lines_cleared), GW'(0));
        chk("rst_score", GW'(score_delta), GW'(0));
        chk("rst_grid", GW'(grid_out), GW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty grid: nothing cleared, output equals input
        g = '0;
        run_op("empty", g, g, 0, 1'b0);

        // Bottom row full, row above it holds one cell
        g = '0;
        g[21] = full_row(4);
        g[20] = '0;
        g[20][0] = 3'd1;
        e = '0;
        e[21][0] = 3'd1;
        g2 = g;
        e2 = e;
        run_op("one_line", g, e, 1, 1'b0);

        // Four full rows under a partial row
        g = '0;
        for (int r = 18; r < 22; r++) g[r] = full_row(r);
        g[17] = partial_row(17);
        e = '0;
        e[21] = partial_row(17);
        run_op("tetris", g, e, 4, 1'b0);

        // Entire field full
        for (int r = 0; r < ROWS; r++) g[r] = full_row(r);
        run_op("all_full", g, '0, 22, 1'b0);

        // Even rows full, odd rows partial; odd rows land in 11..21 in order
        e = '0;
        for (int r = 0; r < ROWS; r++) g[r] = (r % 2 == 0) ? full_row(r) : partial_row(r);
        for (int k = 0; k < 11; k++) e[11 + k] = partial_row(2*k + 1);
        run_op("alternate", g, e, 11, 1'b0);

        // Reset in the middle of a scan abandons the operation
        for (int r = 0; r < ROWS; r++) g[r] = full_row(r);
        grid_in = g;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", GW'(busy), GW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", GW'(busy), GW'(0));
        chk("mid_rst_lines", GW'(lines_cleared), GW'(0));
        chk("mid_rst_score", GW'(score_delta), GW'(0));
        chk("mid_rst_grid", GW'(grid_out), GW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abandoned_no_done", GW'(done_cnt), GW'(0));

        // Fresh run after reset with start held high throughout
        run_op("after_rst", g2, e2, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
